inst_fetch: RTL and testbench
=============================

Name: inst_fetch

Overview:
Instruction fetch stage of the 16-bit RISC core, directly upstream of inst_dec. Holds the PC and issues word reads to instruction memory over a req/ack handshake. Presents one instruction at a time to the decoder, with its PC, and drives the decoder's enable. Supports downstream stall (backpressure) and branch redirect/flush.

Parameters:
PC_WIDTH, 16, width of PC and memory address.
RESET_PC, 16'h0000, PC value loaded on reset.
PC_STEP, 1, PC increment per fetched instruction (word-addressed memory).

Ports:
I_clk  in  1  clock; all state updates on the rising edge.
I_rst  in  1  reset, synchronous to I_clk, active-high.
I_en  in  1  fetch enable; 0 = issue no new requests.
I_stall  in  1  decoder/downstream not ready; holds the current instruction.
I_branch  in  1  one-cycle redirect pulse.
I_branch_target  in  PC_WIDTH  redirect address, sampled when I_branch=1.
O_mem_req  out  1  memory read request.
O_mem_addr  out  PC_WIDTH  read address; stable while O_mem_req=1.
I_mem_ack  in  1  read data valid; earliest one cycle after the request is first asserted.
I_mem_data  in  16  instruction word, valid with I_mem_ack.
O_inst  out  16  instruction to the decoder (drives inst_dec I_inst).
O_inst_pc  out  PC_WIDTH  address of O_inst.
O_inst_valid  out  1  O_inst holds a live instruction.
O_dec_en  out  1  combinational: O_inst_valid & ~I_stall (drives inst_dec I_en).
O_pc  out  PC_WIDTH  address of the next fetch.

Behaviour:
- Reset (I_rst=1 at an edge) overrides everything. Next state: state=S_IDLE, O_pc=RESET_PC, O_mem_req=0, O_mem_addr=RESET_PC, O_inst=0, O_inst_pc=0, O_inst_valid=0, skid empty. An outstanding memory request is abandoned. Memory is required to drop a pending ack on reset.
- Storage: an output register (O_inst/O_inst_pc/O_inst_valid) plus a one-entry skid register.
- Consume event: O_inst_valid & ~I_stall. Output then loads from skid if it is full, otherwise clears valid, unless an ack loads it in the same cycle.
- States:
  - S_IDLE: req=0. Go to S_REQ when I_en=1 and the skid is empty. In S_REQ, O_mem_addr=O_pc.
  - S_REQ: req=1, addr held. On ack:
    - If output is empty or being consumed, the word goes to the output register. Otherwise it goes to skid.
    - O_pc += PC_STEP, wrapping modulo 2^PC_WIDTH (FFFF -> 0000).
    - Next state is S_REQ (back-to-back, new addr) if I_en=1 and the skid will be empty. Otherwise S_IDLE.
  - S_DROP: req=0. Waits for the ack of a flushed request, discards its data, then goes to S_IDLE.
- Throughput: one instruction per cycle with zero-wait memory (ack every cycle after the first) and no stall.
- Latency: request to O_inst_valid is the ack cycle plus 1 edge.
- Branch (I_branch=1, no reset), highest priority after reset:
  - O_pc <= I_branch_target.
  - O_inst_valid <= 0 and skid cleared.
  - From S_REQ without ack in the same cycle: go to S_DROP.
  - From S_REQ with ack in the same cycle: ack data discarded, go to S_IDLE.
  - From S_IDLE: stay in S_IDLE. Fetch of the target starts next cycle.
  - O_dec_en is still asserted in the branch cycle for the current instruction. The issuing stage is responsible for that.
- Never more than one outstanding request. O_mem_req deasserts only on the ack edge, or by moving to S_DROP/S_IDLE after a branch.
- I_en falling while in S_REQ: the request completes, then the block idles. Buffered instructions still drain.

Optional Feature:
Macro FETCH_PERF_EN.
- Defined: adds output O_fetch_cnt[15:0], which increments on each consume event, and output O_bubble_cnt[15:0], which increments each cycle O_inst_valid=0 and I_en=1. Both reset to 0, wrap at FFFF, and freeze while I_en=0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then I_en=1, memory at addr 0 returns 16'b0001011100000100 with a 1-cycle ack -> O_mem_addr=0000, O_inst=0x1704, O_inst_pc=0000, O_dec_en=1, O_pc=0001.
- Zero-wait memory, 4 words at 0..3, no stall -> O_inst_valid high 4 consecutive cycles, O_inst_pc 0,1,2,3.
- I_stall=1 for 3 cycles while 2 acks arrive -> output holds word 0, skid holds word 1, no third request. Release stall -> words 1 and 2 delivered in order, none lost or duplicated.
- I_branch=1, target 0x0040, while a request to 0x0005 is outstanding -> ack for 0x0005 is discarded (never valid), next O_mem_addr=0x0040, O_inst_pc=0x0040.
- I_branch coincident with ack, and separately O_pc=FFFF fetch -> ack data dropped in the first case. In the second, O_pc wraps to 0000.
- I_rst asserted mid-S_REQ with valid output and full skid -> next cycle O_mem_req=0, O_inst_valid=0, O_pc=RESET_PC. With FETCH_PERF_EN, counters=0.

Source files
------------

// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch -- instruction fetch stage of the 16-bit RISC core.
//
// Holds the PC and issues one word read at a time to instruction memory over
// a req/ack handshake. It presents one instruction at a time, with its PC, to
// inst_dec and drives the decoder enable. It supports downstream stall and
// branch redirect/flush.
//
// Storage: an output register (O_inst/O_inst_pc/O_inst_valid) plus a one-entry
// skid register. The skid catches a word that returns while the output is
// stalled. New requests are only issued while the skid is empty, so at most
// two instructions are ever buffered and at most one request is outstanding.
//
// Optional build macro: FETCH_PERF_EN adds O_fetch_cnt / O_bubble_cnt.
//
// Ports:
//   I_clk            clock, rising-edge
//   I_rst            synchronous active-high reset
//   I_en             fetch enable (0 = issue no new requests)
//   I_stall          downstream not ready; hold the current instruction
//   I_branch         one-cycle redirect pulse
//   I_branch_target  redirect address, sampled with I_branch
//   O_mem_req        memory read request
//   O_mem_addr       read address, stable while O_mem_req=1
//   I_mem_ack        read data valid
//   I_mem_data       instruction word, valid with I_mem_ack
//   O_inst           instruction to the decoder
//   O_inst_pc        address of O_inst
//   O_inst_valid     O_inst holds a live instruction
//   O_dec_en         O_inst_valid & ~I_stall (decoder enable)
//   O_pc             address of the next fetch
//   O_fetch_cnt      (FETCH_PERF_EN) consumed-instruction counter
//   O_bubble_cnt     (FETCH_PERF_EN) empty-output cycles while enabled
// -----------------------------------------------------------------------------
module inst_fetch #(
  parameter int                  PC_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC = 16'h0000,
  parameter int                  PC_STEP  = 1
) (
  input  logic                I_clk,
  input  logic                I_rst,
  input  logic                I_en,
  input  logic                I_stall,
  input  logic                I_branch,
  input  logic [PC_WIDTH-1:0] I_branch_target,
  output logic                O_mem_req,
  output logic [PC_WIDTH-1:0] O_mem_addr,
  input  logic                I_mem_ack,
  input  logic [15:0]         I_mem_data,
  output logic [15:0]         O_inst,
  output logic [PC_WIDTH-1:0] O_inst_pc,
  output logic                O_inst_valid,
  output logic                O_dec_en,
  output logic [PC_WIDTH-1:0] O_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]         O_fetch_cnt,
  output logic [15:0]         O_bubble_cnt
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;

  localparam logic [PC_WIDTH-1:0] STEP = PC_WIDTH'(PC_STEP);

  logic [1:0]          state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;

  logic [15:0]         out_inst_q, out_inst_d;
  logic [PC_WIDTH-1:0] out_pc_q, out_pc_d;
  logic                out_valid_q, out_valid_d;

  logic [15:0]         skid_inst_q, skid_inst_d;
  logic [PC_WIDTH-1:0] skid_pc_q, skid_pc_d;
  logic                skid_valid_q, skid_valid_d;

  logic                consume;
  logic                ack_take;

  // The decoder takes the presented instruction this cycle.
  assign consume  = out_valid_q & ~I_stall;
  // A returning word that belongs to the live request (not a flushed one).
  assign ack_take = (state_q == S_REQ) & I_mem_ack;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    out_inst_d   = out_inst_q;
    out_pc_d     = out_pc_q;
    out_valid_d  = out_valid_q;
    skid_inst_d  = skid_inst_q;
    skid_pc_d    = skid_pc_q;
    skid_valid_d = skid_valid_q;

    if (I_branch) begin
      // Redirect: flush everything buffered. A request still in flight has
      // to be waited out in S_DROP unless its ack arrives right now, in which
      // case the word is simply ignored.
      pc_d         = I_branch_target;
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
      case (state_q)
        S_REQ:   state_d = I_mem_ack ? S_IDLE : S_DROP;
        S_DROP:  state_d = I_mem_ack ? S_IDLE : S_DROP;
        default: state_d = S_IDLE;
      endcase
    end else begin
      // Output / skid movement.
      if (consume) begin
        if (skid_valid_q) begin
          out_inst_d   = skid_inst_q;
          out_pc_d     = skid_pc_q;
          out_valid_d  = 1'b1;
          skid_valid_d = 1'b0;
          if (ack_take) begin
            skid_inst_d  = I_mem_data;
            skid_pc_d    = pc_q;
            skid_valid_d = 1'b1;
          end
        end else if (ack_take) begin
          out_inst_d  = I_mem_data;
          out_pc_d    = pc_q;
          out_valid_d = 1'b1;
        end else begin
          out_valid_d = 1'b0;
        end
      end else if (!out_valid_q) begin
        // Output empty; the skid is never full here, so the word goes
        // straight to the output.
        if (ack_take) begin
          out_inst_d  = I_mem_data;
          out_pc_d    = pc_q;
          out_valid_d = 1'b1;
        end
      end else if (ack_take) begin
        // Output held by a stall: park the returning word in the skid.
        skid_inst_d  = I_mem_data;
        skid_pc_d    = pc_q;
        skid_valid_d = 1'b1;
      end

      // Request sequencing.
      case (state_q)
        S_IDLE: begin
          if (I_en && !skid_valid_q) begin
            state_d = S_REQ;
          end
        end
        S_REQ: begin
          if (I_mem_ack) begin
            pc_d = pc_q + STEP;
            // Keep requesting back-to-back only while there is guaranteed
            // room for the next word.
            state_d = (I_en && !skid_valid_d) ? S_REQ : S_IDLE;
          end
        end
        S_DROP: begin
          if (I_mem_ack) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      out_inst_q   <= '0;
      out_pc_q     <= '0;
      out_valid_q  <= 1'b0;
      skid_inst_q  <= '0;
      skid_pc_q    <= '0;
      skid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      out_inst_q   <= out_inst_d;
      out_pc_q     <= out_pc_d;
      out_valid_q  <= out_valid_d;
      skid_inst_q  <= skid_inst_d;
      skid_pc_q    <= skid_pc_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  // The PC only moves on the ack edge or on a redirect, so it doubles as
  // the request address and stays stable for the life of a request.
  assign O_mem_req    = (state_q == S_REQ);
  assign O_mem_addr   = pc_q;
  assign O_pc         = pc_q;
  assign O_inst       = out_inst_q;
  assign O_inst_pc    = out_pc_q;
  assign O_inst_valid = out_valid_q;
  assign O_dec_en     = consume;

`ifdef FETCH_PERF_EN
  logic [15:0] fetch_cnt_q;
  logic [15:0] bubble_cnt_q;

  // Both counters freeze while fetch is disabled and wrap naturally.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      fetch_cnt_q  <= 16'd0;
      bubble_cnt_q <= 16'd0;
    end else if (I_en) begin
      if (consume) begin
        fetch_cnt_q <= fetch_cnt_q + 16'd1;
      end
      if (!out_valid_q) begin
        bubble_cnt_q <= bubble_cnt_q + 16'd1;
      end
    end
  end

  assign O_fetch_cnt  = fetch_cnt_q;
  assign O_bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch -- self-checking bench for inst_fetch.
//
// A behavioural instruction memory answers requests with a configurable wait
// (first word of a burst no earlier than one cycle after the request appears,
// back-to-back words can return immediately). Directed table rows and short
// hand-written sequences cover the stall/skid, branch and wrap corners; a
// randomized run is checked against an in-order program-stream model: every
// instruction handed to the decoder must be the next address in program order
// (advanced on each consume, restarted on branch/reset) with the memory word
// stored there.
// -----------------------------------------------------------------------------
module tb_inst_fetch;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        I_rst, I_en, I_stall, I_branch;
  logic [15:0] I_branch_target;
  logic        O_mem_req;
  logic [15:0] O_mem_addr;
  logic        I_mem_ack;
  logic [15:0] I_mem_data;
  logic [15:0] O_inst, O_inst_pc, O_pc;
  logic        O_inst_valid, O_dec_en;
`ifdef FETCH_PERF_EN
  logic [15:0] O_fetch_cnt, O_bubble_cnt;
  logic [15:0] fc_m, bc_m;
`endif

  int errors = 0;
  int checks = 0;

  inst_fetch dut (
    .I_clk           (clk),
    .I_rst           (I_rst),
    .I_en            (I_en),
    .I_stall         (I_stall),
    .I_branch        (I_branch),
    .I_branch_target (I_branch_target),
    .O_mem_req       (O_mem_req),
    .O_mem_addr      (O_mem_addr),
    .I_mem_ack       (I_mem_ack),
    .I_mem_data      (I_mem_data),
    .O_inst          (O_inst),
    .O_inst_pc       (O_inst_pc),
    .O_inst_valid    (O_inst_valid),
    .O_dec_en        (O_dec_en),
    .O_pc            (O_pc)
`ifdef FETCH_PERF_EN
    ,
    .O_fetch_cnt     (O_fetch_cnt),
    .O_bubble_cnt    (O_bubble_cnt)
`endif
  );

  // ---------------------------------------------------------------- memory
  function automatic logic [15:0] memw(input logic [15:0] a);
    logic [15:0] t;
    if (a == 16'h0000) return 16'h1704;
    t = a * 16'h3B9D;
    return t ^ 16'hC0DE ^ {a[7:0], a[15:8]};
  endfunction

  logic        mo = 1'b0;       // request outstanding
  int          mwait = 0;       // cycles left before ack
  logic [15:0] maddr = 16'h0;
  logic        req_prev = 1'b0;
  logic        req_now = 1'b0;
  logic        started_now = 1'b0;
  int          lat_cfg = 1;
  logic        lat_rand = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic mem_respond();
    int l;
    started_now = 1'b0;
    if (!mo && O_mem_req === 1'b1) begin
      l           = lat_rand ? int'($urandom_range(1, 3)) : lat_cfg;
      mo          = 1'b1;
      maddr       = O_mem_addr;
      mwait       = req_prev ? l - 1 : l;
      started_now = 1'b1;
    end
    if (mo && mwait == 0) begin
      I_mem_ack  = 1'b1;
      I_mem_data = memw(maddr);
    end else begin
      I_mem_ack  = 1'b0;
      I_mem_data = 16'($urandom);
    end
    req_now = (O_mem_req === 1'b1);
  endtask

  task automatic mem_update();
    if (I_rst) begin
      mo       = 1'b0;
      req_prev = 1'b0;
    end else begin
      if (I_mem_ack) mo = 1'b0;
      else if (mo && mwait > 0) mwait--;
      req_prev = req_now;
    end
  endtask

  task automatic drive(input logic rst, input logic en, input logic stall,
                       input logic br, input logic [15:0] tgt);
    I_rst = rst; I_en = en; I_stall = stall; I_branch = br; I_branch_target = tgt;
    mem_respond();
    #1;
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    mem_update();
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    advance();
  endtask

  // Runs enabled, unstalled cycles until an instruction is presented; stays
  // in that cycle so the caller can inspect it.
  task automatic run_until_valid(input int max, output logic found,
                                 output logic [15:0] first_req);
    logic seen_req;
    found = 1'b0; seen_req = 1'b0; first_req = 16'hxxxx;
    for (int i = 0; i < max; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
      if (!seen_req && O_mem_req) begin
        seen_req = 1'b1; first_req = O_mem_addr;
      end
      if (O_inst_valid) begin
        found = 1'b1;
        break;
      end
      advance();
    end
  endtask

  // ----------------------------------------------------------------- table
  typedef struct {
    logic        stall;
    logic        req;
    logic [15:0] addr;
    logic        valid;
    logic [15:0] ipc;
    logic        dec_en;
    logic [15:0] pc;
  } vec_t;

  vec_t tbl[11];

  initial begin
    logic        found;
    logic [15:0] freq;
    logic        rst, en, st, br;
    logic [15:0] tgt, exp_pc;
    int          n_cons;

    tbl[0]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000};
    tbl[1]  = '{1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000};
    tbl[2]  = '{1'b1, 1'b1, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000};
    tbl[3]  = '{1'b1, 1'b1, 16'h0001, 1'b1, 16'h0000, 1'b0, 16'h0001};
    tbl[4]  = '{1'b1, 1'b0, 16'h0002, 1'b1, 16'h0000, 1'b0, 16'h0002};
    tbl[5]  = '{1'b0, 1'b0, 16'h0002, 1'b1, 16'h0000, 1'b1, 16'h0002};
    tbl[6]  = '{1'b0, 1'b0, 16'h0002, 1'b1, 16'h0001, 1'b1, 16'h0002};
    tbl[7]  = '{1'b0, 1'b1, 16'h0002, 1'b0, 16'h0000, 1'b0, 16'h0002};
    tbl[8]  = '{1'b0, 1'b1, 16'h0002, 1'b0, 16'h0000, 1'b0, 16'h0002};
    tbl[9]  = '{1'b0, 1'b1, 16'h0003, 1'b1, 16'h0002, 1'b1, 16'h0003};
    tbl[10] = '{1'b0, 1'b1, 16'h0004, 1'b1, 16'h0003, 1'b1, 16'h0004};

    I_rst = 1'b1; I_en = 1'b0; I_stall = 1'b0; I_branch = 1'b0;
    I_branch_target = 16'h0; I_mem_ack = 1'b0; I_mem_data = 16'h0;

    // ---- stall / skid table (row 0 is the first cycle after reset)
    do_reset();
    for (int i = 0; i < 11; i++) begin
      drive(1'b0, 1'b1, tbl[i].stall, 1'b0, 16'h0);
      $display("vec %0d: stall=%b req=%b addr=%h valid=%b ipc=%h inst=%h dec_en=%b pc=%h",
               i, tbl[i].stall, O_mem_req, O_mem_addr, O_inst_valid, O_inst_pc, O_inst,
               O_dec_en, O_pc);
      if (i == 0) begin
        check("reset_inst", O_inst, 16'h0000);
        check("reset_inst_pc", O_inst_pc, 16'h0000);
`ifdef FETCH_PERF_EN
        check("reset_fetch_cnt", O_fetch_cnt, 16'h0);
        check("reset_bubble_cnt", O_bubble_cnt, 16'h0);
`endif
      end
      check($sformatf("vec%0d_req", i), O_mem_req, tbl[i].req);
      if (tbl[i].req) check($sformatf("vec%0d_addr", i), O_mem_addr, tbl[i].addr);
      check($sformatf("vec%0d_valid", i), O_inst_valid, tbl[i].valid);
      if (tbl[i].valid) begin
        check($sformatf("vec%0d_inst_pc", i), O_inst_pc, tbl[i].ipc);
        check($sformatf("vec%0d_inst", i), O_inst, memw(tbl[i].ipc));
      end
      check($sformatf("vec%0d_dec_en", i), O_dec_en, tbl[i].dec_en);
      check($sformatf("vec%0d_pc", i), O_pc, tbl[i].pc);
      advance();
    end

    // ---- first fetch and zero-wait throughput
    do_reset();
    for (int c = 0; c < 7; c++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
      if (c == 2) begin
        check("first_req", O_mem_req, 1'b1);
        check("first_addr", O_mem_addr, 16'h0000);
      end
      if (c == 3) begin
        check("first_inst", O_inst, 16'h1704);
        check("first_dec_en", O_dec_en, 1'b1);
        check("first_pc", O_pc, 16'h0001);
      end
      if (c >= 3) begin
        check($sformatf("thru_valid_c%0d", c), O_inst_valid, 1'b1);
        check($sformatf("thru_inst_pc_c%0d", c), O_inst_pc, 16'(c - 3));
      end
      advance();
    end
    $display("seq throughput: done, last inst_pc=%h", O_inst_pc);

    // ---- reset mid-request (row 3) and with a full skid (row 4)
    for (int ra = 3; ra <= 4; ra++) begin
      do_reset();
      for (int c = 0; c < ra; c++) begin
        drive(1'b0, 1'b1, tbl[c].stall, 1'b0, 16'h0);
        advance();
      end
      drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h0);
      check($sformatf("rst%0d_pre_valid", ra), O_inst_valid, 1'b1);
      advance();
      drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
      check($sformatf("rst%0d_req", ra), O_mem_req, 1'b0);
      check($sformatf("rst%0d_valid", ra), O_inst_valid, 1'b0);
      check($sformatf("rst%0d_pc", ra), O_pc, 16'h0000);
      check($sformatf("rst%0d_inst_pc", ra), O_inst_pc, 16'h0000);
`ifdef FETCH_PERF_EN
      check($sformatf("rst%0d_fetch_cnt", ra), O_fetch_cnt, 16'h0);
      check($sformatf("rst%0d_bubble_cnt", ra), O_bubble_cnt, 16'h0);
`endif
      advance();
      run_until_valid(8, found, freq);
      check($sformatf("rst%0d_refetch_timeout", ra), found, 1'b1);
      check($sformatf("rst%0d_refetch_pc", ra), O_inst_pc, 16'h0000);
      check($sformatf("rst%0d_refetch_inst", ra), O_inst, 16'h1704);
      advance();
      $display("seq reset at row %0d: refetch inst_pc=%h", ra, O_inst_pc);
    end

    // ---- branch while a request to 0x0005 is outstanding
    do_reset();
    lat_cfg = 3;
    drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h0005); advance();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
    check("br_idle_pc", O_pc, 16'h0005);
    advance();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
    check("br_req5", O_mem_req, 1'b1);
    check("br_addr5", O_mem_addr, 16'h0005);
    advance();
    drive(1'b0, 1'b1, 1'b0, 1'b1, 16'h0040);
    advance();
    lat_cfg = 1;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
    check("br_drop_req", O_mem_req, 1'b0);
    check("br_drop_pc", O_pc, 16'h0040);
    advance();
    run_until_valid(12, found, freq);
    check("br_timeout", found, 1'b1);
    check("br_next_addr", freq, 16'h0040);
    check("br_inst_pc", O_inst_pc, 16'h0040);
    check("br_inst", O_inst, memw(16'h0040));
    advance();
    $display("seq branch outstanding: first req=%h inst_pc=%h", freq, O_inst_pc);

    // ---- branch coincident with ack
    do_reset();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0); advance();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0); advance();
    drive(1'b0, 1'b1, 1'b0, 1'b1, 16'h0010);
    check("brack_ack_present", I_mem_ack & O_mem_req, 1'b1);
    advance();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
    check("brack_valid", O_inst_valid, 1'b0);
    check("brack_req", O_mem_req, 1'b0);
    check("brack_pc", O_pc, 16'h0010);
    advance();
    run_until_valid(8, found, freq);
    check("brack_timeout", found, 1'b1);
    check("brack_next_addr", freq, 16'h0010);
    check("brack_inst_pc", O_inst_pc, 16'h0010);
    advance();
    $display("seq branch with ack: first req=%h inst_pc=%h", freq, O_inst_pc);

    // ---- PC wrap FFFF -> 0000
    do_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 16'hFFFF); advance();
    run_until_valid(8, found, freq);
    check("wrap_timeout", found, 1'b1);
    check("wrap_first_addr", freq, 16'hFFFF);
    check("wrap_inst_pc", O_inst_pc, 16'hFFFF);
    check("wrap_inst", O_inst, memw(16'hFFFF));
    check("wrap_pc", O_pc, 16'h0000);
    check("wrap_next_addr", O_mem_addr, 16'h0000);
    advance();
    $display("seq wrap: inst_pc=%h next pc=%h", O_inst_pc, O_pc);

    // ---- randomized run against the program-stream model
    do_reset();
    lat_rand = 1'b1;
    exp_pc = 16'h0000;
    n_cons = 0;
`ifdef FETCH_PERF_EN
    fc_m = 16'h0; bc_m = 16'h0;
`endif
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst = ($urandom_range(0, 199) == 0);
      en  = ($urandom_range(0, 9) != 0);
      st  = ($urandom_range(0, 9) < 3);
      br  = !rst && ($urandom_range(0, 29) == 0);
      tgt = ($urandom_range(0, 3) == 0) ? 16'(16'hFFFD + $urandom_range(0, 4))
                                        : 16'($urandom);
      drive(rst, en, st, br, tgt);
      check("rnd_dec_en", O_dec_en, O_inst_valid & ~st);
      if (O_inst_valid) begin
        check("rnd_inst_pc", O_inst_pc, exp_pc);
        check("rnd_inst", O_inst, memw(O_inst_pc));
      end
      if (mo && O_mem_req && !started_now) check("rnd_addr_stable", O_mem_addr, maddr);
`ifdef FETCH_PERF_EN
      if (rst) begin
        fc_m = 16'h0; bc_m = 16'h0;
      end else if (en) begin
        if (O_inst_valid && !st) fc_m = fc_m + 16'h1;
        if (!O_inst_valid) bc_m = bc_m + 16'h1;
      end
`endif
      if (O_inst_valid && !st) begin
        exp_pc = exp_pc + 16'h1;
        n_cons++;
      end
      if (rst) exp_pc = 16'h0000;
      else if (br) exp_pc = tgt;
      advance();
      if (rst) begin
        check("rnd_rst_valid", O_inst_valid, 1'b0);
        check("rnd_rst_pc", O_pc, 16'h0000);
      end else if (br) begin
        check("rnd_br_valid", O_inst_valid, 1'b0);
        check("rnd_br_pc", O_pc, tgt);
      end
`ifdef FETCH_PERF_EN
      check("rnd_fetch_cnt", O_fetch_cnt, fc_m);
      check("rnd_bubble_cnt", O_bubble_cnt, bc_m);
`endif
    end
    check("rnd_progress", (n_cons >= 200), 1'b1);
    $display("seq random: %0d instructions consumed", n_cons);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
